// File: rtl/mac_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mac_pkg : shared widths, FSM encoding and overflow-aware adder for the MAC.
// Config  : SATURATE_EN selects clamping (defined) or wrapping (undefined).
// Rev 1.0
// ----------------------------------------------------------------------------
package mac_pkg;

  localparam int OP_W   = 8;
  localparam int PROD_W = 16;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  // Adds two w-bit signed values carried sign-extended in 32 bits; returns {sum, ovf}.
  function automatic logic [32:0] sat_add(input logic signed [31:0] acc,
                                          input logic signed [31:0] p,
                                          input int w);
    longint s;
    longint vmax;
    longint vmin;
    logic   ovf;
    s    = longint'(acc) + longint'(p);
    vmax = (longint'(1) <<< (w - 1)) - 1;
    vmin = -vmax - 1;
    ovf  = (s > vmax) || (s < vmin);
`ifdef SATURATE_EN
    if (s > vmax) s = vmax;
    else if (s < vmin) s = vmin;
`endif
    return {32'(s), ovf};
  endfunction

endpackage
`default_nettype wire

// File: rtl/Radix_4_8x8.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Radix_4_8x8 : combinational signed 8x8 radix-4 Booth multiplier.
// Rev 1.0
// ----------------------------------------------------------------------------
module Radix_4_8x8
  import mac_pkg::*;
(
  input  logic signed [OP_W-1:0]   X,
  input  logic signed [OP_W-1:0]   Y,
  output logic signed [PROD_W-1:0] P
);

  logic [OP_W:0]     w_ybits;
  logic [PROD_W-1:0] w_xe;
  logic [PROD_W-1:0] w_pp;
  logic [PROD_W-1:0] w_sum;

  assign w_ybits = {Y, 1'b0};
  assign w_xe    = {{(PROD_W-OP_W){X[OP_W-1]}}, X};

  // Modulo-2^16 summation is exact because every 8x8 signed product fits in 16 bits.
  always_comb begin
    w_pp  = '0;
    w_sum = '0;
    for (int i = 0; i < OP_W/2; i++) begin
      case (w_ybits[2*i +: 3])
        3'b001, 3'b010: w_pp = w_xe;
        3'b011:         w_pp = w_xe << 1;
        3'b100:         w_pp = -(w_xe << 1);
        3'b101, 3'b110: w_pp = -w_xe;
        default:        w_pp = '0;
      endcase
      w_sum = w_sum + (w_pp << (2*i));
    end
  end

  assign P = w_sum;

endmodule
`default_nettype wire

// File: rtl/booth_mac_accum.sv
`default_nettype none
// ----------------------------------------------------------------------------
// booth_mac_accum : streaming signed dot-product accumulator around a Booth
// multiplier. Config: SATURATE_EN clamps the accumulator instead of wrapping.
// Rev 1.0
// ----------------------------------------------------------------------------
module booth_mac_accum
  import mac_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int LEN_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [OP_W-1:0]  in_a,
  input  logic signed [OP_W-1:0]  in_b,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_acc,
  output logic [LEN_W-1:0]        out_count,
  output logic                    out_ovf
);

  localparam logic [LEN_W-1:0] C_CNT_MAX = '1;

  logic [1:0]              r_state;
  logic                    r_s1_vld;
  logic signed [OP_W-1:0]  r_s1_a;
  logic signed [OP_W-1:0]  r_s1_b;
  logic                    r_s1_last;
  logic signed [ACC_W-1:0] r_acc;
  logic [LEN_W-1:0]        r_count;
  logic                    r_ovf;

  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_p;
  logic signed [ACC_W-1:0]  w_acc_base;
  logic [LEN_W-1:0]         w_cnt_base;
  logic [LEN_W-1:0]         w_cnt_next;
  logic                     w_ovf_base;
  logic [32:0]              w_add;
  logic                     w_unused_add;
  logic                     w_accept;

  Radix_4_8x8 u_mult (
    .X (r_s1_a),
    .Y (r_s1_b),
    .P (w_prod)
  );

  assign w_p = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};

  // A fresh vector starts from zero even if the first beat lands straight out of IDLE.
  assign w_acc_base = (r_state == S_IDLE) ? '0 : r_acc;
  assign w_cnt_base = (r_state == S_IDLE) ? '0 : r_count;
  assign w_ovf_base = (r_state == S_IDLE) ? 1'b0 : r_ovf;
  assign w_cnt_next = (w_cnt_base == C_CNT_MAX) ? w_cnt_base : w_cnt_base + LEN_W'(1);

  assign w_add        = sat_add(32'(w_acc_base), 32'(w_p), ACC_W);
  assign w_unused_add = ^w_add;

  assign in_ready  = rst_n && (r_state != S_DONE) && !(r_s1_vld && r_s1_last);
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (r_state == S_DONE);
  assign out_acc   = r_acc;
  assign out_count = r_count;
  assign out_ovf   = r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_s1_vld  <= 1'b0;
      r_s1_a    <= '0;
      r_s1_b    <= '0;
      r_s1_last <= 1'b0;
      r_acc     <= '0;
      r_count   <= '0;
      r_ovf     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_s1_vld  <= 1'b1;
        r_s1_a    <= in_a;
        r_s1_b    <= in_b;
        r_s1_last <= in_last;
      end else begin
        r_s1_vld  <= 1'b0;
        r_s1_a    <= '0;
        r_s1_b    <= '0;
        r_s1_last <= 1'b0;
      end

      if (r_s1_vld) begin
        r_acc   <= w_add[ACC_W:1];
        r_ovf   <= w_ovf_base | w_add[0];
        r_count <= w_cnt_next;
        r_state <= r_s1_last ? S_DONE : S_ACCUM;
      end else if ((r_state == S_DONE) && out_ready) begin
        r_state <= S_IDLE;
        r_acc   <= '0;
        r_count <= '0;
        r_ovf   <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
